// File: rtl/usb_data_fifo.sv
// -----------------------------------------------------------------------------
// usb_data_fifo
//   First-word-fall-through data queue between a USB packet source and an AXI
//   side consumer. The source has no backpressure, so pushes into a full queue
//   are dropped. Each drop sets a sticky overflow flag and increments a
//   saturating drop counter.
//
// Ports
//   axi_clk          in   sole clock, rising edge
//   rst              in   synchronous active-high reset
//   flush_i          in   synchronous flush of entries and status
//   usb_data_i       in   write data [DATA_W]
//   usb_data_valid_i in   push request
//   usb_data_o       out  head-of-queue data (combinational read)
//   usb_data_valid_o out  head entry valid
//   usb_data_ready_i in   consumer accepts head entry
//   count_o          out  occupancy [$clog2(DEPTH)+1]
//   almost_full_o    out  registered (count >= AFULL_THRESH)
//   overflow_o       out  sticky drop flag
//   drop_cnt_o       out  saturating dropped-push count [16]
// -----------------------------------------------------------------------------
module usb_data_fifo #(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
   input  logic                     axi_clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic [DATA_W-1:0]        usb_data_i,
   input  logic                     usb_data_valid_i,
   output logic [DATA_W-1:0]        usb_data_o,
   output logic                     usb_data_valid_o,
   input  logic                     usb_data_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     almost_full_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);
   localparam logic [CW-1:0] AfullC = CW'(AFULL_THRESH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("usb_data_fifo: DEPTH must be a power of 2 and at least 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("usb_data_fifo: AFULL_THRESH must lie in 1..DEPTH");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;
   logic              r_afull;
   logic              r_overflow;
   logic [15:0]       r_drop_cnt;

   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_wr_en;
   logic [CW-1:0]     w_count_next;

   // A pop frees a slot in the same cycle, so a full queue still accepts a push
   // alongside it.
   assign w_pop   = (r_count != '0) && usb_data_ready_i;
   assign w_push  = usb_data_valid_i && ((r_count < DepthC) || w_pop);
   assign w_drop  = usb_data_valid_i && !w_push;
   assign w_wr_en = w_push && !rst && !flush_i;

   always_comb begin
      w_count_next = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Storage has no reset; valid/count gate every read so stale words never show.
   always_ff @(posedge axi_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= usb_data_i;
      end
   end

   always_ff @(posedge axi_clk) begin
      if (rst || flush_i) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_afull    <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_next;
         r_afull <= (w_count_next >= AfullC);
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
               r_drop_cnt <= r_drop_cnt + 16'd1;
            end
         end
      end
   end

   assign usb_data_o       = r_mem[r_rd_ptr];
   assign usb_data_valid_o = (r_count != '0);
   assign count_o          = r_count;
   assign almost_full_o    = r_afull;
   assign overflow_o       = r_overflow;
   assign drop_cnt_o       = r_drop_cnt;

endmodule

// File: tb/tb_usb_data_fifo.sv
// -----------------------------------------------------------------------------
// tb_usb_data_fifo
//   Self-checking bench for usb_data_fifo (DATA_W=64, DEPTH=8, AFULL_THRESH=6).
//   A behavioural queue model takes words as they are driven and pops them as
//   the DUT hands them out; every cycle the DUT status is compared with it.
//   Directed scenarios add fixed-value checks on top.
// -----------------------------------------------------------------------------
module tb_usb_data_fifo;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned AFULL  = DEPTH - 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush_i;
   logic [DATA_W-1:0] usb_data_i;
   logic              usb_data_valid_i;
   logic [DATA_W-1:0] usb_data_o;
   logic              usb_data_valid_o;
   logic              usb_data_ready_i;
   logic [3:0]        count_o;
   logic              almost_full_o;
   logic              overflow_o;
   logic [15:0]       drop_cnt_o;

   int n_chk = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   logic [63:0] m_q[$];
   bit          m_ovf = 1'b0;
   int          m_drop = 0;

   usb_data_fifo #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL)
   ) u_dut (
      .axi_clk          (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .usb_data_i       (usb_data_i),
      .usb_data_valid_i (usb_data_valid_i),
      .usb_data_o       (usb_data_o),
      .usb_data_valid_o (usb_data_valid_o),
      .usb_data_ready_i (usb_data_ready_i),
      .count_o          (count_o),
      .almost_full_o    (almost_full_o),
      .overflow_o       (overflow_o),
      .drop_cnt_o       (drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are then stable.
   task automatic step(input logic v, input logic [63:0] d, input logic r,
                       input logic f, input logic rs);
      usb_data_valid_i = v;
      usb_data_i       = d;
      usb_data_ready_i = r;
      flush_i          = f;
      rst              = rs;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare status against the model, then advance the model using
   // the inputs that the coming rising edge will sample.
   always @(negedge clk) begin
      if (mon_en) begin
         bit pop;
         bit push;
         chk("m_count", 64'(count_o), 64'(m_q.size()));
         chk("m_valid", 64'(usb_data_valid_o), 64'(m_q.size() != 0));
         chk("m_afull", 64'(almost_full_o), 64'(m_q.size() >= AFULL));
         chk("m_ovf", 64'(overflow_o), 64'(m_ovf));
         chk("m_drop", 64'(drop_cnt_o), 64'(m_drop));
         if (usb_data_valid_o && usb_data_ready_i && m_q.size() != 0) begin
            chk("m_pop_data", usb_data_o, m_q[0]);
         end
         if (rst || flush_i) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
         end else begin
            pop  = (m_q.size() != 0) && usb_data_ready_i;
            push = usb_data_valid_i && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(usb_data_i);
            if (usb_data_valid_i && !push) begin
               m_ovf = 1'b1;
               if (m_drop != 65535) m_drop++;
            end
         end
      end
   end

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 1);
      chk("rst_count", 64'(count_o), 0);
      chk("rst_valid", 64'(usb_data_valid_o), 0);
      chk("rst_afull", 64'(almost_full_o), 0);
      chk("rst_ovf", 64'(overflow_o), 0);
      chk("rst_drop", 64'(drop_cnt_o), 0);

      // Ready while empty must not underflow.
      step(0, 0, 1, 0, 0);
      chk("empty_rdy_count", 64'(count_o), 0);
      chk("empty_rdy_valid", 64'(usb_data_valid_o), 0);

      // Single-word latency.
      step(1, 64'hA5, 0, 0, 0);
      chk("lat_valid", 64'(usb_data_valid_o), 1);
      chk("lat_data", usb_data_o, 64'hA5);
      chk("lat_count", 64'(count_o), 1);
      step(0, 0, 1, 0, 0);
      chk("lat_pop_valid", 64'(usb_data_valid_o), 0);
      chk("lat_pop_count", 64'(count_o), 0);

      // Fill past full with ready low.
      for (int i = 1; i <= 10; i++) begin
         step(1, 64'(i), 0, 0, 0);
         chk("fill_count", 64'(count_o), 64'((i > 8) ? 8 : i));
         chk("fill_afull", 64'(almost_full_o), 64'(i >= 6));
      end
      chk("fill_ovf", 64'(overflow_o), 1);
      chk("fill_drop", 64'(drop_cnt_o), 2);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_data", usb_data_o, 64'(i));
         step(0, 0, 1, 0, 0);
      end
      chk("drain_count", 64'(count_o), 0);
      chk("ovf_sticky", 64'(overflow_o), 1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 8; i++) step(1, 64'(11 + i), 0, 0, 0);
      step(1, 64'h99, 1, 0, 0);
      chk("fullpp_count", 64'(count_o), 8);
      chk("fullpp_drop", 64'(drop_cnt_o), 2);
      for (int i = 0; i < 7; i++) begin
         chk("fullpp_data", usb_data_o, 64'(12 + i));
         step(0, 0, 1, 0, 0);
      end
      chk("fullpp_last", usb_data_o, 64'h99);
      step(0, 0, 1, 0, 0);
      chk("fullpp_empty", 64'(count_o), 0);

      // Flush with pending entries and status, together with a push.
      for (int i = 0; i < 8; i++) step(1, 64'h20 + 64'(i), 0, 0, 0);
      step(1, 64'h30, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("pre_flush_count", 64'(count_o), 5);
      chk("pre_flush_drop", 64'(drop_cnt_o), 3);
      step(1, 64'h77, 0, 1, 0);
      chk("flush_count", 64'(count_o), 0);
      chk("flush_valid", 64'(usb_data_valid_o), 0);
      chk("flush_ovf", 64'(overflow_o), 0);
      chk("flush_drop", 64'(drop_cnt_o), 0);
      step(1, 64'h55, 0, 0, 0);
      chk("post_flush_head", usb_data_o, 64'h55);
      chk("post_flush_count", 64'(count_o), 1);
      step(0, 0, 1, 0, 0);

      // Continuous streaming across several pointer wraps.
      step(1, 64'h100, 0, 0, 0);
      for (int k = 1; k < 3 * DEPTH; k++) begin
         chk("wrap_data", usb_data_o, 64'h100 + 64'(k - 1));
         step(1, 64'h100 + 64'(k), 1, 0, 0);
         chk("wrap_count", 64'(count_o), 1);
      end
      chk("wrap_last", usb_data_o, 64'h100 + 64'(3 * DEPTH - 1));
      step(0, 0, 1, 0, 0);
      chk("wrap_drop", 64'(drop_cnt_o), 0);

      // Reset mid-operation while popping.
      for (int i = 0; i < 4; i++) step(1, 64'h40 + 64'(i), 0, 0, 0);
      chk("pre_rst_count", 64'(count_o), 4);
      step(1, 64'h4F, 1, 0, 1);
      chk("midrst_count", 64'(count_o), 0);
      chk("midrst_valid", 64'(usb_data_valid_o), 0);
      chk("midrst_afull", 64'(almost_full_o), 0);
      chk("midrst_ovf", 64'(overflow_o), 0);
      chk("midrst_drop", 64'(drop_cnt_o), 0);
      step(1, 64'h42, 0, 0, 0);
      chk("postrst_head", usb_data_o, 64'h42);
      chk("postrst_count", 64'(count_o), 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
